bp_stream_host_endpoint: RTL

- Far end of the BlackParrot MMIO stream link; sits on the host/FPGA side, facing the BP-side stream MMIO bridge.
- Deframes the inbound word stream of (address, data) pairs into single-beat requests on a simple memory-mapped target port.
- Returns each read's dword result as a serialized word stream, low word first. Writes generate no return traffic.

---
 rtl/bp_stream_host_endpoint.sv | 215 +++++++++++++++++++++
 1 files changed

// File: rtl/bp_stream_host_endpoint.sv
// bp_stream_host_endpoint: turns inbound (address, data) word pairs into single-beat target requests and returns read dwords as words, low word first.
// Latency: at least 3 cycles per request (addr, data, issue); mem_data_v_i to first stream_v_o is 2 cycles when the return path is empty.
// Backpressure: words are consumed only in S_ADDR/S_DATA, reads hold at zero credits, and outbound words are held stable until stream_ready_i.
// Optional: define BP_STREAM_HOST_COUNTERS_EN to add rd_count_o, wr_count_o and err_o.

// bp_stream_host_fifo: small registered FIFO for the read-return dwords.
// Latency: a push becomes visible at the head one cycle later.
// Backpressure: none on push; the caller guarantees it never pushes when full.
module bp_stream_host_fifo #(
  parameter int width_p = 64,
  parameter int depth_p = 4
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               in_vld,
  input  logic [width_p-1:0] in_dat,
  output logic               out_vld,
  output logic [width_p-1:0] out_dat,
  input  logic               out_rdy
);
  localparam int ptr_w = (depth_p > 1) ? $clog2(depth_p) : 1;
  localparam int cnt_w = $clog2(depth_p + 1);

  logic [width_p-1:0] mem_r [depth_p];
  logic [ptr_w-1:0]   wptr_r, rptr_r;
  logic [cnt_w-1:0]   cnt_r;
  logic               pop;

  assign out_vld = (cnt_r != '0);
  assign out_dat = mem_r[rptr_r];
  assign pop     = out_vld & out_rdy;

  // Storage needs no reset: only entries counted by cnt_r are ever read.
  always_ff @(posedge clk_i) begin
    if (in_vld) mem_r[wptr_r] <= in_dat;
  end

  // Pointers and occupancy.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      wptr_r <= '0;
      rptr_r <= '0;
      cnt_r  <= '0;
    end else begin
      if (in_vld) wptr_r <= (wptr_r == ptr_w'(depth_p - 1)) ? '0 : wptr_r + 1'b1;
      if (pop)    rptr_r <= (rptr_r == ptr_w'(depth_p - 1)) ? '0 : rptr_r + 1'b1;
      case ({in_vld, pop})
        2'b10:   cnt_r <= cnt_r + 1'b1;
        2'b01:   cnt_r <= cnt_r - 1'b1;
        default: cnt_r <= cnt_r;
      endcase
    end
  end
endmodule

module bp_stream_host_endpoint #(
  parameter int stream_data_width_p = 32,
  parameter int addr_width_p        = 28,
  parameter int dword_width_p       = 64,
  parameter int rd_credits_p        = 4
) (
  input  logic                           clk_i,
  input  logic                           reset_i,
  input  logic                           stream_v_i,
  input  logic [stream_data_width_p-1:0] stream_data_i,
  output logic                           stream_yumi_o,
  output logic                           stream_v_o,
  output logic [stream_data_width_p-1:0] stream_data_o,
  input  logic                           stream_ready_i,
  output logic                           mem_v_o,
  output logic                           mem_w_o,
  output logic [addr_width_p-1:0]        mem_addr_o,
  output logic [stream_data_width_p-1:0] mem_data_o,
  input  logic                           mem_ready_i,
  input  logic                           mem_data_v_i,
  input  logic [dword_width_p-1:0]       mem_data_i
`ifdef BP_STREAM_HOST_COUNTERS_EN
  ,
  output logic [31:0]                    rd_count_o,
  output logic [31:0]                    wr_count_o,
  output logic                           err_o
`endif
);
  localparam int words_lp = dword_width_p / stream_data_width_p;
  localparam int idx_w    = (words_lp > 1) ? $clog2(words_lp) : 1;
  localparam int cr_w     = $clog2(rd_credits_p + 1);
  localparam logic [idx_w-1:0] last_idx_lp = idx_w'(words_lp - 1);

  typedef enum logic [1:0] {S_ADDR, S_DATA, S_ISSUE} state_e;

  state_e                         state_r;
  logic                           w_r;
  logic [addr_width_p-1:0]        addr_r;
  logic [stream_data_width_p-1:0] data_r;
  logic [cr_w-1:0]                credits_r;
  logic [cr_w-1:0]                rd_out_r;

  logic                           rd_issue, wr_issue, ret_accept;
  logic                           fifo_vld, piso_load, word_fire, last_fire;
  logic [dword_width_p-1:0]       fifo_dat;
  logic                           piso_vld_r;
  logic [dword_width_p-1:0]       piso_dat_r;
  logic [idx_w-1:0]               idx_r;

  // Reset gates the consume strobe so no word is taken while reset is held.
  assign stream_yumi_o = stream_v_i & ~reset_i & (state_r != S_ISSUE);
  assign mem_v_o       = (state_r == S_ISSUE) & (w_r | (credits_r != '0));
  assign mem_w_o       = w_r;
  assign mem_addr_o    = addr_r;
  assign mem_data_o    = data_r;

  assign rd_issue   = mem_v_o & mem_ready_i & ~w_r;
  assign wr_issue   = mem_v_o & mem_ready_i & w_r;
  // Data with no read outstanding is a protocol error and is dropped.
  assign ret_accept = mem_data_v_i & (rd_out_r != '0);

  // Deframing FSM: address word, data word, then hold the request until the target takes it.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      state_r <= S_ADDR;
      w_r     <= 1'b0;
      addr_r  <= '0;
      data_r  <= '0;
    end else begin
      case (state_r)
        S_ADDR: if (stream_v_i) begin
          w_r     <= stream_data_i[stream_data_width_p-1];
          addr_r  <= stream_data_i[addr_width_p-1:0];
          state_r <= S_DATA;
        end
        S_DATA: if (stream_v_i) begin
          data_r  <= stream_data_i;
          state_r <= S_ISSUE;
        end
        S_ISSUE: if (mem_v_o && mem_ready_i) state_r <= S_ADDR;
        default: state_r <= S_ADDR;
      endcase
    end
  end

  // Credits cover a read from issue until its last word leaves the PISO.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) credits_r <= cr_w'(rd_credits_p);
    else case ({rd_issue, last_fire})
      2'b10:   credits_r <= credits_r - 1'b1;
      2'b01:   credits_r <= credits_r + 1'b1;
      default: credits_r <= credits_r;
    endcase
  end

  // Reads issued to the target whose data has not yet come back.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) rd_out_r <= '0;
    else case ({rd_issue, ret_accept})
      2'b10:   rd_out_r <= rd_out_r + 1'b1;
      2'b01:   rd_out_r <= rd_out_r - 1'b1;
      default: rd_out_r <= rd_out_r;
    endcase
  end

  bp_stream_host_fifo #(
    .width_p (dword_width_p),
    .depth_p (rd_credits_p)
  ) ret_fifo (
    .clk_i   (clk_i),
    .reset_i (reset_i),
    .in_vld  (ret_accept),
    .in_dat  (mem_data_i),
    .out_vld (fifo_vld),
    .out_dat (fifo_dat),
    .out_rdy (piso_load)
  );

  assign piso_load     = fifo_vld & ~piso_vld_r;
  assign word_fire     = piso_vld_r & stream_ready_i;
  assign last_fire     = word_fire & (idx_r == last_idx_lp);
  assign stream_v_o    = piso_vld_r;
  assign stream_data_o = piso_dat_r[stream_data_width_p-1:0];

  // PISO: load a dword when empty, shift one word out per accepted beat.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      piso_vld_r <= 1'b0;
      piso_dat_r <= '0;
      idx_r      <= '0;
    end else if (piso_load) begin
      piso_vld_r <= 1'b1;
      piso_dat_r <= fifo_dat;
      idx_r      <= '0;
    end else if (word_fire) begin
      piso_dat_r <= piso_dat_r >> stream_data_width_p;
      idx_r      <= idx_r + 1'b1;
      if (last_fire) piso_vld_r <= 1'b0;
    end
  end

  // Unexpected return data and credit overflow are protocol violations.
  assert property (@(posedge clk_i) disable iff (reset_i) mem_data_v_i |-> (rd_out_r != '0));
  assert property (@(posedge clk_i) disable iff (reset_i) credits_r <= cr_w'(rd_credits_p));

`ifdef BP_STREAM_HOST_COUNTERS_EN
  // Issue counters (wrapping) and sticky error flag.
  always_ff @(posedge clk_i or posedge reset_i) begin
    if (reset_i) begin
      rd_count_o <= '0;
      wr_count_o <= '0;
      err_o      <= 1'b0;
    end else begin
      if (rd_issue) rd_count_o <= rd_count_o + 32'd1;
      if (wr_issue) wr_count_o <= wr_count_o + 32'd1;
      if (mem_data_v_i && (rd_out_r == '0)) err_o <= 1'b1;
    end
  end
`endif
endmodule
